// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: AHB-Lite master that runs one complete SPI transaction on
// the AHBspi peripheral per client request.
// Order of accesses: CTRL, SS and TXDATA writes, then STATUS polls until
// write-done, then an RXDATA read that also clears the flags.
// Optional feature: define SPI_SEQ_TIMEOUT_EN to abort polling after TMO_POLLS
// polls. The RXDATA read is still issued, and the response is flagged with rsp_err.
module spi_xfer_sequencer #(
   parameter logic [31:0] SPI_BASE  = 32'h0,
   parameter int unsigned POLL_GAP  = 8,
   parameter int unsigned TMO_POLLS = 1024
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_ctrl,
   input  logic [31:0] req_ss,
   input  logic [31:0] req_data,
   input  logic [2:0]  req_size,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY
);

   localparam int unsigned GAP_W    = 16;
   localparam int unsigned PCNT_W   = 16;
   localparam int unsigned DONE_BIT = 4;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0]  SIZE_WORD     = 3'b010;

   localparam logic [31:0] ADDR_CTRL = SPI_BASE;
   localparam logic [31:0] ADDR_STAT = SPI_BASE;
   localparam logic [31:0] ADDR_SS   = SPI_BASE + 32'h4;
   localparam logic [31:0] ADDR_TX   = SPI_BASE + 32'h8;
   localparam logic [31:0] ADDR_RX   = SPI_BASE + 32'hC;

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_CTRL, S_D_CTRL,
      S_A_SS,   S_D_SS,
      S_A_TX,   S_D_TX,
      S_A_POLL, S_D_POLL,
      S_GAP,
      S_A_RX,   S_D_RX,
      S_RESP
   } state_t;

   state_t           state;
   logic [31:0]      ctrl_q;
   logic [31:0]      ss_q;
   logic [31:0]      data_q;
   logic [2:0]       size_q;
   logic [GAP_W-1:0] gap_cnt;
   logic             tmo_hit_c;

`ifdef SPI_SEQ_TIMEOUT_EN
   logic [PCNT_W-1:0] poll_cnt;

   // Poll budget exhausted: leave the poll loop and drain RXDATA.
   assign tmo_hit_c = 32'(poll_cnt) >= TMO_POLLS;
`else
   logic unused_tmo;

   assign tmo_hit_c  = 1'b0;
   assign unused_tmo = ^32'(TMO_POLLS);
`endif

   // Sequencer FSM. Every bus and client output is registered here.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         HADDR     <= '0;
         HTRANS    <= HTRANS_IDLE;
         HWRITE    <= 1'b0;
         HSIZE     <= '0;
         HWDATA    <= '0;
         ctrl_q    <= '0;
         ss_q      <= '0;
         data_q    <= '0;
         size_q    <= '0;
         gap_cnt   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
         poll_cnt  <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  ctrl_q    <= req_ctrl;
                  ss_q      <= req_ss;
                  data_q    <= req_data;
                  size_q    <= req_size;
                  req_ready <= 1'b0;
                  rsp_err   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
                  poll_cnt  <= '0;
`endif
                  HADDR     <= ADDR_CTRL;
                  HWRITE    <= 1'b1;
                  HSIZE     <= SIZE_WORD;
                  HTRANS    <= HTRANS_NONSEQ;
                  state     <= S_A_CTRL;
               end
            end
            S_A_CTRL: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  HWDATA <= ctrl_q;
                  state  <= S_D_CTRL;
               end
            end
            S_D_CTRL: begin
               if (HREADY) begin
                  HADDR  <= ADDR_SS;
                  HWRITE <= 1'b1;
                  HSIZE  <= SIZE_WORD;
                  HTRANS <= HTRANS_NONSEQ;
                  state  <= S_A_SS;
               end
            end
            S_A_SS: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  HWDATA <= ss_q;
                  state  <= S_D_SS;
               end
            end
            S_D_SS: begin
               if (HREADY) begin
                  HADDR  <= ADDR_TX;
                  HWRITE <= 1'b1;
                  HSIZE  <= size_q;
                  HTRANS <= HTRANS_NONSEQ;
                  state  <= S_A_TX;
               end
            end
            S_A_TX: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  HWDATA <= data_q;
                  state  <= S_D_TX;
               end
            end
            S_D_TX: begin
               if (HREADY) begin
                  HADDR  <= ADDR_STAT;
                  HWRITE <= 1'b0;
                  HSIZE  <= SIZE_WORD;
                  HTRANS <= HTRANS_NONSEQ;
                  state  <= S_A_POLL;
               end
            end
            S_A_POLL: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  state  <= S_D_POLL;
               end
            end
            S_D_POLL: begin
               if (HREADY) begin
`ifdef SPI_SEQ_TIMEOUT_EN
                  if (poll_cnt != '1) begin
                     poll_cnt <= poll_cnt + PCNT_W'(1);
                  end
`endif
                  if (HRDATA[DONE_BIT]) begin
                     HADDR  <= ADDR_RX;
                     HWRITE <= 1'b0;
                     HSIZE  <= SIZE_WORD;
                     HTRANS <= HTRANS_NONSEQ;
                     state  <= S_A_RX;
                  end else begin
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  HWRITE <= 1'b0;
                  HSIZE  <= SIZE_WORD;
                  HTRANS <= HTRANS_NONSEQ;
                  if (tmo_hit_c) begin
                     rsp_err <= 1'b1;
                     HADDR   <= ADDR_RX;
                     state   <= S_A_RX;
                  end else begin
                     HADDR   <= ADDR_STAT;
                     state   <= S_A_POLL;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_A_RX: begin
               if (HREADY) begin
                  HTRANS <= HTRANS_IDLE;
                  state  <= S_D_RX;
               end
            end
            S_D_RX: begin
               if (HREADY) begin
                  rsp_data  <= HRDATA;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: randomized bench for spi_xfer_sequencer with a
// reactive AHB slave and a transaction-level reference model.
module tb_spi_xfer_sequencer;

   localparam int unsigned G    = 8;
   localparam int unsigned TMO  = 4;
   localparam logic [31:0] BASE = 32'h0;
   localparam logic [1:0]  T_IDLE   = 2'b00;
   localparam logic [1:0]  T_NONSEQ = 2'b10;
   localparam logic [2:0]  WORD = 3'b010;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_ctrl;
   logic [31:0] req_ss;
   logic [31:0] req_data;
   logic [2:0]  req_size;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = 32'h0;
   logic        HREADY = 1'b1;

   spi_xfer_sequencer #(
      .SPI_BASE  (BASE),
      .POLL_GAP  (G),
      .TMO_POLLS (TMO)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctrl  (req_ctrl),
      .req_ss    (req_ss),
      .req_data  (req_data),
      .req_size  (req_size),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY)
   );

   always #5 HCLK = ~HCLK;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge HCLK) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   op_t op_log[$];
   op_t exp_ops[$];

   // slave configuration and bookkeeping
   int          cfg_done_at  = 1;
   int          cfg_smode    = 0;
   logic [31:0] cfg_rx       = 32'h0;
   int          status_reads = 0;
   int          stall_total  = 0;
   int          poll_cyc[$];
   bit          in_data  = 1'b0;
   bit          first_dp = 1'b0;
   int          wait_left = 0;
   op_t         cur;

   // Reactive AHB slave: decides HREADY/HRDATA for the next edge and logs completed transfers.
   always @(negedge HCLK) begin
      logic [31:0] rv;
      if (!HRESETn) begin
         in_data = 1'b0;
         HREADY  = 1'b1;
      end else if (in_data) begin
         check_eq("dp_htrans", 32'(HTRANS), 32'(T_IDLE));
         check_eq("dp_haddr",  HADDR, cur.addr);
         check_eq("dp_hwrite", 32'(HWRITE), 32'(cur.wr));
         check_eq("dp_hsize",  32'(HSIZE), 32'(cur.size));
         if (first_dp) cur.wdata = HWDATA;
         else if (cur.wr) check_eq("dp_hwdata_hold", HWDATA, cur.wdata);
         first_dp = 1'b0;
         if (wait_left > 0) begin
            HREADY = 1'b0;
            HRDATA = $urandom;
            wait_left--;
            stall_total++;
         end else begin
            HREADY = 1'b1;
            rv = $urandom;
            if (!cur.wr && cur.addr == BASE) begin
               status_reads++;
               rv[4] = (cfg_done_at != 0) && (status_reads >= cfg_done_at);
            end else if (!cur.wr && cur.addr == BASE + 32'hC) begin
               rv = cfg_rx;
            end
            HRDATA = rv;
            if (!cur.wr) cur.wdata = 32'h0;
            op_log.push_back(cur);
            in_data = 1'b0;
         end
      end else begin
         HREADY = 1'b1;
         HRDATA = $urandom;
         if (HTRANS != T_IDLE) begin
            check_eq("at_htrans", 32'(HTRANS), 32'(T_NONSEQ));
            cur.addr  = HADDR;
            cur.wr    = HWRITE;
            cur.size  = HSIZE;
            cur.wdata = 32'h0;
            in_data   = 1'b1;
            first_dp  = 1'b1;
            case (cfg_smode)
               1:       wait_left = $urandom_range(0, 2);
               2:       wait_left = (HWRITE && HADDR == BASE + 32'h8) ? 3 : 0;
               default: wait_left = 0;
            endcase
            if (!HWRITE && HADDR == BASE) poll_cyc.push_back(cyc);
         end
      end
   end

   // reference model state for the pending transaction
   logic [31:0] p_ctrl, p_ss, p_data;
   logic [2:0]  p_size;
   int          exp_polls;
   bit          exp_tmo;

   function automatic void push_op(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                   input logic [31:0] d);
      op_t o;
      o.addr  = a;
      o.wr    = w;
      o.size  = sz;
      o.wdata = d;
      exp_ops.push_back(o);
   endfunction

   task automatic setup_xfer(input logic [31:0] c, input logic [31:0] s, input logic [31:0] d,
                             input logic [2:0] sz, input int done_at, input int smode);
      p_ctrl = c;
      p_ss   = s;
      p_data = d;
      p_size = sz;
      cfg_done_at  = done_at;
      cfg_smode    = smode;
      cfg_rx       = $urandom;
      status_reads = 0;
      stall_total  = 0;
      poll_cyc.delete();
      exp_tmo   = (done_at == 0);
      exp_polls = exp_tmo ? int'(TMO) : done_at;
      exp_ops.delete();
      push_op(BASE,          1'b1, WORD, c);
      push_op(BASE + 32'h4,  1'b1, WORD, s);
      push_op(BASE + 32'h8,  1'b1, sz,   d);
      for (int i = 0; i < exp_polls; i++) push_op(BASE, 1'b0, WORD, 32'h0);
      push_op(BASE + 32'hC, 1'b0, WORD, 32'h0);
   endtask

   task automatic issue_req(output int waits);
      req_ctrl  = p_ctrl;
      req_ss    = p_ss;
      req_data  = p_data;
      req_size  = p_size;
      req_valid = 1'b1;
      waits = 0;
      while (req_ready !== 1'b1 && waits < 50) begin
         @(negedge HCLK);
         waits++;
      end
      check_eq("accept_ready", 32'(req_ready), 32'h1);
      @(posedge HCLK);
      #1;
      req_valid = 1'b0;
      check_eq("ready_drop", 32'(req_ready), 32'h0);
   endtask

   task automatic compare_ops();
      check_eq("op_count", 32'(op_log.size()), 32'(exp_ops.size()));
      for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++) begin
         check_eq($sformatf("op%0d_addr", i), op_log[i].addr, exp_ops[i].addr);
         check_eq($sformatf("op%0d_write", i), 32'(op_log[i].wr), 32'(exp_ops[i].wr));
         check_eq($sformatf("op%0d_size", i), 32'(op_log[i].size), 32'(exp_ops[i].size));
         if (exp_ops[i].wr) check_eq($sformatf("op%0d_wdata", i), op_log[i].wdata, exp_ops[i].wdata);
      end
      op_log.delete();
   endtask

   // Waits for rsp_valid after an accept; returns on the negedge that sees it.
   task automatic await_rsp(input int poke_at);
      int n;
      bit got;
      int exp_lat;
      n   = 0;
      got = 1'b0;
      while (n < 3000 && !got) begin
         @(negedge HCLK);
         n++;
         if (poke_at != 0 && n == poke_at) begin
            req_valid = 1'b1;
            req_data  = $urandom;
         end
         if (poke_at != 0 && n == poke_at + 1) req_valid = 1'b0;
         if (rsp_valid === 1'b1) got = 1'b1;
      end
      check_eq("rsp_seen", 32'(got), 32'h1);
      if (got) begin
         exp_lat = 11 + (exp_polls - 1) * (2 + int'(G)) + (exp_tmo ? int'(G) : 0) + stall_total;
         check_eq("latency", 32'(n), 32'(exp_lat));
         check_eq("rsp_data", rsp_data, cfg_rx);
         check_eq("rsp_err", 32'(rsp_err), 32'(exp_tmo));
         check_eq("ready_in_resp", 32'(req_ready), 32'h0);
         compare_ops();
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'h1);
      check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check_eq({pfx, "_rsp_data"},  rsp_data, 32'h0);
      check_eq({pfx, "_rsp_err"},   32'(rsp_err), 32'h0);
      check_eq({pfx, "_htrans"},    32'(HTRANS), 32'h0);
      check_eq({pfx, "_haddr"},     HADDR, 32'h0);
      check_eq({pfx, "_hwrite"},    32'(HWRITE), 32'h0);
      check_eq({pfx, "_hsize"},     32'(HSIZE), 32'h0);
      check_eq({pfx, "_hwdata"},    HWDATA, 32'h0);
   endtask

   initial begin
      repeat (20000) @(posedge HCLK);
      $display("FAIL watchdog: cycle budget exhausted, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int n;
      logic [31:0] last_rx;
      HRESETn   = 1'b0;
      req_valid = 1'b0;
      req_ctrl  = 32'h0;
      req_ss    = 32'h0;
      req_data  = 32'h0;
      req_size  = 3'h0;
      repeat (3) @(negedge HCLK);
      check_reset_vals("por");
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("idle_ready", 32'(req_ready), 32'h1);

      // directed: halfword TX, done on first poll
      setup_xfer(32'h2040, 32'h1, 32'h1108, 3'b001, 1, 0);
      issue_req(w);
      await_rsp(0);
      last_rx = cfg_rx;
      @(negedge HCLK);
      check_eq("ready_after_rsp", 32'(req_ready), 32'h1);
      check_eq("rsp_pulse_one", 32'(rsp_valid), 32'h0);
      repeat (3) @(negedge HCLK);
      check_eq("rsp_data_held", rsp_data, last_rx);

      // directed: three not-done polls, then done
      setup_xfer(32'h0001, 32'h4, 32'hCAFE_F00D, WORD, 4, 0);
      cfg_rx = 32'h01020304;
      issue_req(w);
      await_rsp(0);
      check_eq("poll_count", 32'(poll_cyc.size()), 32'h4);
      for (int i = 1; i < poll_cyc.size(); i++)
         check_eq($sformatf("poll_spacing%0d", i), 32'(poll_cyc[i] - poll_cyc[i-1]), 32'(2 + G));

      // directed: three wait states on the TX data phase
      setup_xfer(32'h00FF, 32'h8, 32'h0000_00A5, 3'b000, 1, 2);
      issue_req(w);
      await_rsp(0);

      // directed: poke while busy, then a request coincident with rsp_valid
      setup_xfer(32'h1111, 32'h2, 32'h2222, WORD, 1, 0);
      issue_req(w);
      await_rsp(5);
      setup_xfer(32'h3333, 32'h10, 32'h4444, 3'b001, 2, 0);
      issue_req(w);
      check_eq("coincident_accept_wait", 32'(w), 32'h1);
      await_rsp(0);

`ifdef SPI_SEQ_TIMEOUT_EN
      // directed: STATUS never reports done
      setup_xfer(32'h5555, 32'h1, 32'h6666, WORD, 0, 0);
      issue_req(w);
      await_rsp(0);
`endif

      // randomized transactions with random wait states and busy pokes
      for (int k = 0; k < 12; k++) begin
         setup_xfer($urandom, 32'h1 << $urandom_range(0, 31), $urandom,
                    3'($urandom_range(0, 2)), $urandom_range(1, 3), 1);
         issue_req(w);
         await_rsp((k % 2 == 1) ? $urandom_range(3, 8) : 0);
      end

      // reset during the STATUS data phase
      setup_xfer(32'h7777, 32'h1, 32'h8888, WORD, 3, 0);
      issue_req(w);
      n = 0;
      while (n < 100 && !(HTRANS == T_NONSEQ && HADDR == BASE && HWRITE == 1'b0)) begin
         @(negedge HCLK);
         n++;
      end
      check_eq("reach_poll", 32'(n < 100), 32'h1);
      @(posedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("ready_after_rst", 32'(req_ready), 32'h1);
      op_log.delete();

      // recovery transaction
      setup_xfer(32'h2040, 32'h1, 32'h1108, 3'b001, 1, 0);
      issue_req(w);
      await_rsp(0);

      repeat (2) @(negedge HCLK);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
